adc_serial_responder: RTL and testbench

ADC_SERIAL_RESPONDER -- requirements
Module: adc_serial_responder

---
 rtl/adc_resp_pkg.sv | 17 +
 rtl/sync_edge.sv | 43 ++++
 rtl/adc_serial_responder.sv | 163 ++++++++++++++++
 tb/tb_adc_serial_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_resp_pkg.sv
// adc_resp_pkg
// Shared types and constants for the ADC serial responder.
//   state_t   : responder FSM states (IDLE / SHIFT / CONVERT)
//   SAMPLE_W  : serial sample width in bits
//   BIT_CNT_W : width of the shifted-bit counter (must hold SAMPLE_W)
package adc_resp_pkg;

  localparam int unsigned SAMPLE_W  = 8;
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CONVERT = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Multi-stage synchronizer for an asynchronous 1-bit input followed by
// single-cycle rise/fall pulse generation on the synchronized value.
// Parameters:
//   STAGES  : synchronizer depth (>= 2)
//   RST_VAL : value the synchronizer and edge history take in reset, so
//             that leaving reset never produces a spurious edge
// Ports:
//   clk  : system clock (rising edge)
//   rstn : synchronous reset, active-high
//   din  : asynchronous input
//   rise : one-cycle pulse on a synchronized 0->1 transition
//   fall : one-cycle pulse on a synchronized 1->0 transition
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;
  logic              sync;

  always_ff @(posedge clk) begin
    if (rstn) begin
      sr   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr   <= {sr[STAGES-2:0], din};
      prev <= sr[STAGES-1];
    end
  end

  assign sync = sr[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/adc_serial_responder.sv
// adc_serial_responder
// Emulates a serial ADC for a reader: on a chip-select fall the held sample
// is shifted out MSB first on adclk falling edges; a complete read (8 bits)
// is followed by a CONV_CYCLES-long conversion, at whose end the newest
// pending sample (if any) becomes the next value served.
// Optional feature macro: ADC_RESP_AUTOINC_EN -- when defined, a conversion
// with no pending sample increments the held value (mod 256) instead of
// keeping it.
// Parameters:
//   CONV_CYCLES : conversion time in clk cycles (>= 2)
//   SYNC_STAGES : synchronizer depth for adcs/adclk (>= 2)
// Ports:
//   clk          : system clock (rising edge)
//   rstn         : synchronous reset, active-high
//   adcs         : chip select from reader, active-low (asynchronous)
//   adclk        : serial clock from reader (asynchronous)
//   ad_data      : serial data out, MSB first, 0 outside SHIFT
//   sample_in    : next sample value to serve
//   sample_valid : sample_in valid
//   sample_ready : sample accepted this cycle (high in IDLE/SHIFT)
//   busy         : high in SHIFT or CONVERT
//   conv_err     : one-cycle pulse on aborted read or CS during conversion
module adc_serial_responder
  import adc_resp_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                adcs,
  input  logic                adclk,
  output logic                ad_data,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                busy,
  output logic                conv_err
);

  localparam int unsigned          CNT_W     = $clog2(CONV_CYCLES);
  localparam logic [CNT_W-1:0]     CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BITS_ALL  = BIT_CNT_W'(SAMPLE_W);

  state_t                state, state_n;
  logic [SAMPLE_W-1:0]   shift_reg;
  logic [SAMPLE_W-1:0]   hold_reg;
  logic [SAMPLE_W-1:0]   pend_reg;
  logic                  pend_flag;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]      conv_cnt;
  logic [SAMPLE_W-1:0]   hold_no_pend;

  logic cs_rise, cs_fall, sck_fall, sck_rise_unused;
  logic do_load, do_shift, conv_done, err_c, accept;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .rstn (rstn),
    .din  (adcs),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // adclk rising edges are deliberately ignored.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk  (clk),
    .rstn (rstn),
    .din  (adclk),
    .rise (sck_rise_unused),
    .fall (sck_fall)
  );

`ifdef ADC_RESP_AUTOINC_EN
  assign hold_no_pend = hold_reg + SAMPLE_W'(1);
`else
  assign hold_no_pend = hold_reg;
`endif

  // Next-state and control decode. A CS rise in SHIFT wins over a
  // simultaneous adclk fall, so that shift is dropped.
  always_comb begin
    state_n   = state;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    conv_done = 1'b0;
    err_c     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n = SHIFT;
          do_load = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (bit_cnt == BITS_ALL) begin
            state_n = CONVERT;
          end else begin
            state_n = IDLE;
            err_c   = 1'b1;
          end
        end else if (sck_fall) begin
          do_shift = 1'b1;
        end
      end
      CONVERT: begin
        if (cs_fall) err_c = 1'b1;
        if (conv_cnt == CONV_LAST) begin
          state_n   = IDLE;
          conv_done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are gated by reset so they read idle values throughout reset.
  assign ad_data      = ~rstn & (state == SHIFT) & shift_reg[SAMPLE_W-1];
  assign busy         = ~rstn & ((state == SHIFT) | (state == CONVERT));
  assign sample_ready = rstn | (state != CONVERT);
  assign conv_err     = ~rstn & err_c;
  assign accept       = sample_valid & sample_ready;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      pend_reg  <= '0;
      pend_flag <= 1'b0;
      bit_cnt   <= '0;
      conv_cnt  <= '0;
    end else begin
      state <= state_n;

      if (do_load) begin
        shift_reg <= hold_reg;
        bit_cnt   <= '0;
      end else if (do_shift) begin
        shift_reg <= {shift_reg[SAMPLE_W-2:0], 1'b0};
        if (bit_cnt != BITS_ALL) bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == CONVERT && !conv_done) conv_cnt <= conv_cnt + 1'b1;
      else                                conv_cnt <= '0;

      // accept and conv_done are mutually exclusive: ready is low in CONVERT.
      if (conv_done) begin
        if (pend_flag) begin
          hold_reg  <= pend_reg;
          pend_flag <= 1'b0;
        end else begin
          hold_reg  <= hold_no_pend;
        end
      end else if (accept) begin
        pend_reg  <= sample_in;
        pend_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
module tb_adc_serial_responder;
  import adc_resp_pkg::*;

  localparam int unsigned CONV = 24;
  localparam int unsigned SS   = 2;
  localparam int          HALF = SS + 3;

  logic       clk = 1'b0;
  logic       rstn, adcs, adclk, ad_data, sample_valid, sample_ready, busy, conv_err;
  logic [7:0] sample_in;

  always #5 clk = ~clk;

  adc_serial_responder #(.CONV_CYCLES(CONV), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .adcs         (adcs),
    .adclk        (adclk),
    .ad_data      (ad_data),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .conv_err     (conv_err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int err_pulses = 0;

  // Reference model: value served by the next read, and the pending sample.
  logic [7:0] m_hold, m_pend;
  bit         m_flag;
  logic [7:0] last_byte;

  always @(posedge clk) begin
    #1;
    if (conv_err === 1'b1) err_pulses++;
  end

  initial begin
    #1_000_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_convert();
    if (m_flag) begin
      m_hold = m_pend;
      m_flag = 0;
    end else begin
`ifdef ADC_RESP_AUTOINC_EN
      m_hold = m_hold + 8'd1;
`endif
    end
  endtask

  task automatic push(input logic [7:0] v);
    chk("ready_idle", sample_ready, 1);
    sample_in    = v;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    m_pend = v;
    m_flag = 1;
  endtask

  // One read of nf adclk falls; nf >= 8 is a complete read plus conversion.
  task automatic do_read(input int nf, input bit glitch);
    logic [7:0] e;
    int         e0, n;
    bit         full;
    e    = m_hold;
    e0   = err_pulses;
    full = (nf >= 8);
    last_byte = '0;
    adcs = 1'b0;
    tick(HALF);
    for (int i = 0; i <= nf; i++) begin
      if (i < 8) begin
        last_byte[7-i] = ad_data;
        chk("bit", ad_data, e[7-i]);
      end else begin
        chk("bit_tail", ad_data, 0);
      end
      if (i < nf) begin
        adclk = 1'b1; tick(HALF);
        adclk = 1'b0; tick(HALF);
      end
    end
    chk("busy_shift", busy, 1);
    adcs = 1'b1;
    n = 0;
    for (int k = 0; k < int'(CONV) + 40; k++) begin
      if (glitch && k == 8) adcs = 1'b0;
      if (glitch && k == 8 + HALF) begin
        chk("glitch_ad_data", ad_data, 0);
        chk("glitch_busy", busy, 1);
        adcs = 1'b1;
      end
      if (full && !glitch && k == int'(CONV) / 2) chk("ready_convert", sample_ready, 0);
      tick(1);
      if (busy !== 1'b1) break;
      n++;
    end
    chk("busy_done", busy, 0);
    if (full) begin
      chk("conv_len", (n >= int'(CONV) && n <= int'(CONV + SS) + 2), 1);
      chk("conv_err_full", err_pulses - e0, glitch ? 1 : 0);
      model_convert();
    end else begin
      chk("abort_len", (n <= int'(SS) + 2), 1);
      chk("conv_err_abort", err_pulses - e0, 1);
    end
    chk("ad_data_idle", ad_data, 0);
    chk("ready_idle_after", sample_ready, 1);
    tick(2);
  endtask

  task automatic apply_reset();
    rstn = 1'b1; adcs = 1'b1; adclk = 1'b0; sample_valid = 1'b0;
    tick(3);
    chk("rst_ad_data", ad_data, 0);
    chk("rst_ready", sample_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_conv_err", conv_err, 0);
    rstn = 1'b0;
    tick(2);
    m_hold = '0; m_pend = '0; m_flag = 0;
  endtask

  initial begin
    int e0, np, nf;
    sample_in = '0;
    apply_reset();

    // Initial held value is zero.
    do_read(8, 0);
    chk("first_read", last_byte, 8'h00);

    // Load 0xA5 through a conversion, then read it back.
    push(8'hA5);
    do_read(8, 0);
    do_read(8, 0);
    chk("read_a5", last_byte, 8'hA5);

    // Aborted read after 3 falls leaves the value intact.
    do_read(3, 0);
    do_read(8, 0);
    chk("after_abort", last_byte, 8'hA5);

    // CS fall during conversion: error pulse, timing unchanged, next read ok.
    push(8'h3C);
    do_read(8, 1);
    do_read(8, 0);
    chk("after_glitch", last_byte, 8'h3C);

    // Overwrite of pending samples keeps the newest.
    push(8'h11);
    push(8'h22);
    do_read(8, 0);
    do_read(10, 0);
    chk("overwrite", last_byte, 8'h22);

    // 0xFF with no new push: wraps to 0x00 when auto-increment is built in.
    push(8'hFF);
    do_read(8, 0);
    do_read(8, 0);
    chk("ff_loaded", last_byte, 8'hFF);
    do_read(8, 0);
`ifdef ADC_RESP_AUTOINC_EN
    chk("ff_next", last_byte, 8'h00);
`else
    chk("ff_next", last_byte, 8'hFF);
`endif

    // Randomized pushes and read lengths against the model.
    for (int it = 0; it < 8; it++) begin
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) push(8'($urandom_range(0, 255)));
      case ($urandom_range(0, 2))
        0:       nf = $urandom_range(0, 7);
        1:       nf = 8;
        default: nf = 9 + $urandom_range(0, 2);
      endcase
      do_read(nf, 0);
    end

    // Reset in the middle of a read: no error pulse, value back to 0x00.
    push(8'h5A);
    e0 = err_pulses;
    adcs = 1'b0;
    tick(HALF);
    for (int i = 0; i < 4; i++) begin
      adclk = 1'b1; tick(HALF);
      adclk = 1'b0; tick(HALF);
    end
    rstn = 1'b1; adcs = 1'b1;
    tick(1);
    chk("midrst_ad_data", ad_data, 0);
    chk("midrst_busy", busy, 0);
    tick(3);
    rstn = 1'b0;
    tick(HALF);
    chk("midrst_idle_busy", busy, 0);
    chk("midrst_ad_data_after", ad_data, 0);
    chk("midrst_no_err", err_pulses - e0, 0);
    m_hold = '0; m_pend = '0; m_flag = 0;
    do_read(8, 0);
    chk("midrst_hold", last_byte, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
